// File: rtl/ddr3_pg_arb_pkg.sv
// ddr3_pg_arb shared definitions
// state encoding, page op codes, default address width
`timescale 1ns/1ps
package ddr3_pg_arb_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ISSUE   = 3'd1;
  localparam logic [2:0] ST_ENG_REL = 3'd2;
  localparam logic [2:0] ST_ACK     = 3'd3;
  localparam logic [2:0] ST_RELEASE = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE    = ST_IDLE,
    S_ISSUE   = ST_ISSUE,
    S_ENG_REL = ST_ENG_REL,
    S_ACK     = ST_ACK,
    S_RELEASE = ST_RELEASE
  } arb_state_t;

  localparam logic L_PG_OP_WRITE = 1'b0;
  localparam logic L_PG_OP_READ  = 1'b1;

  localparam int P_ADDR_WIDTH_DEF = 28;

endpackage

// File: rtl/ddr3_pg_arb_rr_prio_sel.sv
// rr_prio_sel: first set request bit at or above ptr,
// wrapping modulo N_REQ
`timescale 1ns/1ps
module rr_prio_sel #(
  parameter int N_REQ = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [2:0]       ptr,
  output logic             found,
  output logic [2:0]       idx
);

  logic [2*N_REQ-1:0] dbl;
  logic [2*N_REQ-1:0] rot;
  logic [3:0]         s;

  assign dbl = {req, req};
  assign rot = dbl >> ptr;

  // walk from the top so the lowest rotated hit wins
  always_comb begin
    found = 1'b0;
    s     = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        found = 1'b1;
        s     = {1'b0, ptr} + 4'(k);
      end
    end
    if (s >= 4'(N_REQ)) s = s - 4'(N_REQ);
    idx = s[2:0];
  end

endmodule

// File: rtl/ddr3_pg_arb.sv
// ddr3_pg_arb: round-robin share of the DDR3 page engine
// with per-transfer watchdog and completed-transfer count
`timescale 1ns/1ps
module ddr3_pg_arb
  import ddr3_pg_arb_pkg::*;
#(
  parameter int N_REQ        = 2,
  parameter int P_ADDR_WIDTH = P_ADDR_WIDTH_DEF,
  parameter int P_TO_WIDTH   = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic [N_REQ-1:0]              req,
  input  logic [N_REQ-1:0]              optype,
  input  logic [N_REQ*P_ADDR_WIDTH-1:0] addr,
  output logic [N_REQ-1:0]              ack,
  output logic                          xfer_req,
  output logic                          xfer_optype,
  output logic [P_ADDR_WIDTH-1:0]       xfer_addr,
  input  logic                          xfer_ack,
  output logic [2:0]                    grant_idx,
  output logic                          busy,
  input  logic [P_TO_WIDTH-1:0]         to_limit,
  output logic                          to_err,
  input  logic                          err_clr,
  output logic [31:0]                   n_xfers
);

  arb_state_t             state;
  logic [2:0]             ptr;
  logic [P_TO_WIDTH-1:0]  wd_cnt;
  logic [P_TO_WIDTH-1:0]  wd_nxt;
  logic                   found;
  logic [2:0]             sel_idx;
  logic                   sel_op;
  logic [P_ADDR_WIDTH-1:0] sel_addr;
  logic                   req_g;
  logic [N_REQ-1:0]       ack_g;
  logic [2:0]             ptr_nxt;

  rr_prio_sel #(.N_REQ(N_REQ)) u_sel (
    .req   (req),
    .ptr   (ptr),
    .found (found),
    .idx   (sel_idx)
  );

  always_comb begin
    sel_op   = 1'b0;
    sel_addr = '0;
    req_g    = 1'b0;
    ack_g    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (sel_idx == 3'(i)) begin
        sel_op   = optype[i];
        sel_addr = addr[i*P_ADDR_WIDTH +: P_ADDR_WIDTH];
      end
      if (grant_idx == 3'(i)) begin
        req_g    = req[i];
        ack_g[i] = 1'b1;
      end
    end
  end

  assign ptr_nxt = (grant_idx == 3'(N_REQ - 1)) ? 3'd0
                                                 : grant_idx + 3'd1;
  assign wd_nxt  = (wd_cnt == '1) ? wd_cnt : wd_cnt + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      ptr         <= '0;
      wd_cnt      <= '0;
      ack         <= '0;
      xfer_req    <= 1'b0;
      xfer_optype <= L_PG_OP_WRITE;
      xfer_addr   <= '0;
      grant_idx   <= '0;
      busy        <= 1'b0;
      to_err      <= 1'b0;
      n_xfers     <= '0;
    end else begin
      // a new watchdog hit below overrides the clear
      if (err_clr) to_err <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (en && found) begin
            grant_idx   <= sel_idx;
            xfer_optype <= sel_op;
            xfer_addr   <= sel_addr;
            xfer_req    <= 1'b1;
            busy        <= 1'b1;
            wd_cnt      <= '0;
            state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          wd_cnt <= wd_nxt;
          if (to_limit != '0 && wd_nxt >= to_limit) to_err <= 1'b1;
          if (xfer_ack) begin
            xfer_req <= 1'b0;
            state    <= S_ENG_REL;
          end
        end
        S_ENG_REL: begin
          if (!xfer_ack) begin
            ack     <= ack_g;
            n_xfers <= n_xfers + 32'd1;
            state   <= S_ACK;
          end
        end
        S_ACK: begin
          if (!req_g) begin
            ack   <= '0;
            state <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          ptr   <= ptr_nxt;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr3_pg_arb.sv
// tb_ddr3_pg_arb: directed page transfers, scoreboard of
// expected grants checked whenever xfer_req rises
`timescale 1ns/1ps
module tb_ddr3_pg_arb;
  import ddr3_pg_arb_pkg::*;

  localparam int AW = 28;
  localparam int TW = 16;
  localparam int W_BUSY = 0;
  localparam int W_XREQ = 1;
  localparam int W_XACK = 2;
  localparam int W_ACK0 = 3;
  localparam int W_ACK1 = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            en = 1'b1;
  logic [1:0]      req = '0;
  logic [1:0]      optype = '0;
  logic [2*AW-1:0] addr = '0;
  logic [1:0]      ack;
  logic            xfer_req;
  logic            xfer_optype;
  logic [AW-1:0]   xfer_addr;
  logic            xfer_ack = 1'b0;
  logic [2:0]      grant_idx;
  logic            busy;
  logic [TW-1:0]   to_limit = '0;
  logic            to_err;
  logic            err_clr = 1'b0;
  logic [31:0]     n_xfers;

  ddr3_pg_arb #(.N_REQ(2), .P_ADDR_WIDTH(AW), .P_TO_WIDTH(TW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .req         (req),
    .optype      (optype),
    .addr        (addr),
    .ack         (ack),
    .xfer_req    (xfer_req),
    .xfer_optype (xfer_optype),
    .xfer_addr   (xfer_addr),
    .xfer_ack    (xfer_ack),
    .grant_idx   (grant_idx),
    .busy        (busy),
    .to_limit    (to_limit),
    .to_err      (to_err),
    .err_clr     (err_clr),
    .n_xfers     (n_xfers)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            idx;
    logic          op;
    logic [AW-1:0] a;
  } exp_t;

  exp_t sbq[$];
  int   errs = 0;
  int   checks = 0;
  int   eng_dly = 1;
  int   goal[2] = '{0, 0};
  int   done[2] = '{0, 0};

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(int i, logic op, logic [AW-1:0] a);
    exp_t e;
    e.idx = i;
    e.op  = op;
    e.a   = a;
    sbq.push_back(e);
  endtask

  task automatic set_rq(int i, logic op, logic [AW-1:0] a);
    optype[i] = op;
    addr[i*AW +: AW] = a;
  endtask

  function automatic logic sig(int s);
    case (s)
      W_BUSY:  return busy;
      W_XREQ:  return xfer_req;
      W_XACK:  return xfer_ack;
      W_ACK0:  return ack[0];
      default: return ack[1];
    endcase
  endfunction

  task automatic wait_sig(int s, logic lvl, int budget, string nm);
    int n = 0;
    while (sig(s) !== lvl && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sig(s) !== lvl) chk(nm, 64'(sig(s)), 64'(lvl));
  endtask

  task automatic wait_done(int budget, string nm);
    int n = 0;
    while ((done[0] < goal[0] || done[1] < goal[1]) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 64'(done[0] + done[1]), 64'(goal[0] + goal[1]));
    wait_sig(W_BUSY, 1'b0, 20, {nm, "_idle"});
  endtask

  // requesters: four-phase handshake, one page per goal step
  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
        if (!rst_n) req[i] = 1'b0;
        else if (req[i] && ack[i]) begin
          req[i] = 1'b0;
          done[i]++;
        end else if (!req[i] && !ack[i] && done[i] < goal[i])
          req[i] = 1'b1;
      end
    end
  end

  // transfer engine: ack after eng_dly cycles of xfer_req
  initial begin
    int cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        xfer_ack = 1'b0;
        cnt = 0;
      end else if (xfer_req && !xfer_ack) begin
        cnt++;
        if (cnt >= eng_dly) begin
          xfer_ack = 1'b1;
          cnt = 0;
        end
      end else if (!xfer_req && xfer_ack) xfer_ack = 1'b0;
    end
  end

  // monitor
  initial begin
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (xfer_req && !prev) begin
        if (sbq.size() == 0) chk("sb_unexpected_grant", 64'(grant_idx), 64'hff);
        else begin
          e = sbq.pop_front();
          chk("sb_idx", 64'(grant_idx), 64'(e.idx));
          chk("sb_op", 64'(xfer_optype), 64'(e.op));
          chk("sb_addr", 64'(xfer_addr), 64'(e.a));
        end
      end
      prev = xfer_req;
      chk("ack_excl", 64'((xfer_req && ack != 2'b00) || ack == 2'b11), 64'd0);
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int seen;
    repeat (3) @(negedge clk);
    chk("rst_xfer_req", 64'(xfer_req), 64'd0);
    chk("rst_ack", 64'(ack), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_n_xfers", 64'(n_xfers), 64'd0);
    chk("rst_grant_idx", 64'(grant_idx), 64'd0);
    chk("rst_to_err", 64'(to_err), 64'd0);
    chk("rst_xfer_addr", 64'(xfer_addr), 64'd0);
    chk("rst_xfer_op", 64'(xfer_optype), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // both requesters held busy: strict alternation from ptr=0
    eng_dly = 1;
    set_rq(0, L_PG_OP_READ, 28'h100);
    set_rq(1, L_PG_OP_WRITE, 28'h200);
    for (int k = 0; k < 3; k++) begin
      push(0, L_PG_OP_READ, 28'h100);
      push(1, L_PG_OP_WRITE, 28'h200);
    end
    goal[0] += 3;
    goal[1] += 3;
    wait_done(300, "rr_done");
    chk("rr_n_xfers", 64'(n_xfers), 64'd6);
    chk("rr_sb_empty", 64'(sbq.size()), 64'd0);

    // single slow transfer, ack timing after engine release
    eng_dly = 270;
    set_rq(0, L_PG_OP_WRITE, 28'h0000500);
    push(0, L_PG_OP_WRITE, 28'h0000500);
    goal[0]++;
    wait_sig(W_XACK, 1'b1, 400, "single_xack_hi");
    chk("single_addr", 64'(xfer_addr), 64'h500);
    chk("single_op", 64'(xfer_optype), 64'd0);
    wait_sig(W_XACK, 1'b0, 5, "single_xack_lo");
    chk("single_ack_early", 64'(ack), 64'd0);
    @(negedge clk);
    chk("single_ack_rise", 64'(ack), 64'b01);
    wait_done(20, "single_done");
    chk("single_n_xfers", 64'(n_xfers), 64'd7);

    // inputs change after grant: latched values hold
    eng_dly = 30;
    set_rq(1, L_PG_OP_READ, 28'h10);
    push(1, L_PG_OP_READ, 28'h10);
    goal[1]++;
    wait_sig(W_XREQ, 1'b1, 10, "latch_xreq");
    set_rq(1, L_PG_OP_WRITE, 28'h20);
    wait_sig(W_XACK, 1'b1, 50, "latch_xack");
    chk("latch_addr", 64'(xfer_addr), 64'h10);
    chk("latch_op", 64'(xfer_optype), 64'd1);
    wait_done(20, "latch_done");

    // watchdog fires at ISSUE cycle 100, transfer still completes
    to_limit = 16'd100;
    eng_dly = 150;
    set_rq(0, L_PG_OP_WRITE, 28'h700);
    push(0, L_PG_OP_WRITE, 28'h700);
    goal[0]++;
    wait_sig(W_XREQ, 1'b1, 10, "wd_xreq");
    repeat (99) @(negedge clk);
    chk("wd_not_yet", 64'(to_err), 64'd0);
    @(negedge clk);
    chk("wd_fire", 64'(to_err), 64'd1);
    wait_done(200, "wd_done");
    chk("wd_sticky", 64'(to_err), 64'd1);
    chk("wd_n_xfers", 64'(n_xfers), 64'd9);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("wd_clear", 64'(to_err), 64'd0);
    to_limit = '0;

    // en low mid-transfer: finish, then hold off req1 until en=1
    eng_dly = 20;
    set_rq(0, L_PG_OP_READ, 28'h800);
    push(0, L_PG_OP_READ, 28'h800);
    goal[0]++;
    wait_sig(W_XREQ, 1'b1, 10, "en_xreq");
    en = 1'b0;
    set_rq(1, L_PG_OP_WRITE, 28'h900);
    goal[1]++;
    wait_sig(W_ACK0, 1'b1, 50, "en_ack0");
    wait_sig(W_BUSY, 1'b0, 20, "en_idle");
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (xfer_req || busy) seen = 1;
    end
    chk("en_block", 64'(seen), 64'd0);
    push(1, L_PG_OP_WRITE, 28'h900);
    en = 1'b1;
    wait_sig(W_XREQ, 1'b1, 2, "en_regrant");
    chk("en_grant_idx", 64'(grant_idx), 64'd1);
    wait_done(60, "en_done");
    chk("en_n_xfers", 64'(n_xfers), 64'd11);

    // reset in ACK with ptr=1 and to_err set
    eng_dly = 5;
    set_rq(0, L_PG_OP_WRITE, 28'hA00);
    push(0, L_PG_OP_WRITE, 28'hA00);
    goal[0]++;
    wait_done(40, "rst_pre_done");
    to_limit = 16'd2;
    set_rq(1, L_PG_OP_READ, 28'hB00);
    push(1, L_PG_OP_READ, 28'hB00);
    goal[1]++;
    wait_sig(W_ACK1, 1'b1, 40, "rst_ack1");
    chk("rst_pre_to_err", 64'(to_err), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_ack", 64'(ack), 64'd0);
    chk("rst_mid_xreq", 64'(xfer_req), 64'd0);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_n_xfers", 64'(n_xfers), 64'd0);
    chk("rst_mid_to_err", 64'(to_err), 64'd0);
    goal[0] = done[0];
    goal[1] = done[1];
    to_limit = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    set_rq(0, L_PG_OP_READ, 28'hC00);
    set_rq(1, L_PG_OP_WRITE, 28'hD00);
    push(0, L_PG_OP_READ, 28'hC00);
    push(1, L_PG_OP_WRITE, 28'hD00);
    goal[0]++;
    goal[1]++;
    wait_done(100, "post_rst_done");
    chk("post_rst_n_xfers", 64'(n_xfers), 64'd2);
    chk("final_sb_empty", 64'(sbq.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
